psum_seq_ctrl: RTL and testbench

PSUM_SEQ_CTRL -- requirements
Module: psum_seq_ctrl

---
 rtl/psum_ctrl_pkg.sv | 24 ++
 rtl/psum_addr_gen.sv | 18 +
 rtl/psum_seq_ctrl.sv | 132 +++++++++++++
 tb/tb_psum_seq_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/psum_ctrl_pkg.sv
// Shared types and constants for the partial-sum sequencer and its address generator.
package psum_ctrl_pkg;

  typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, DRAIN, DONE} state_t;

  localparam int BUF_DEPTH    = 30;
  localparam int BEAT_STRIDE  = 8;
  localparam int FIRST_SPAN   = 6;
  localparam int DRAIN_CYCLES = 4;
  localparam int DRAIN_W      = $clog2(DRAIN_CYCLES);

  typedef struct packed {
    logic [2:0] mode;
    logic [2:0] rows;
  } cfg_t;

  // Out-of-range row counts fold onto the nearest legal value.
  function automatic logic [2:0] clamp_rows(input logic [2:0] r, input logic [2:0] max_r);
    if (r == 3'd0) return 3'd1;
    if (r > max_r) return max_r;
    return r;
  endfunction

endpackage

// File: rtl/psum_addr_gen.sv
// Psum buffer head address for beat index k: 0 for the first beat, then FIRST_SPAN + (k-1)*BEAT_STRIDE.
module psum_addr_gen
  import psum_ctrl_pkg::*;
(
  input  logic [2:0] k,
  output logic [5:0] head
);

  logic [6:0] raw;

  always_comb begin
    raw = 7'(FIRST_SPAN) + 7'(BEAT_STRIDE) * (7'(k) - 7'd1);
    if (k == 3'd0)                     head = '0;
    else if (raw > 7'(BUF_DEPTH - 1))  head = 6'(BUF_DEPTH - 1);
    else                               head = raw[5:0];
  end

endmodule

// File: rtl/psum_seq_ctrl.sv
// Layer sequencer for the psum buffer: clear, accumulate rows*chans beats, drain, done.
// Optional stall counter output enabled by defining PSUM_SEQ_CTRL_PERF_EN.
module psum_seq_ctrl
  import psum_ctrl_pkg::*;
#(
  parameter int MAX_ROWS = 4,
  parameter int CHAN_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        cfg_mode,
  input  logic [2:0]        cfg_rows,
  input  logic [CHAN_W-1:0] cfg_chans,
  input  logic              pe_valid,
  output logic              pe_ready,
  output logic              buf_clear,
  output logic              buf_enable,
  output logic              buf_first,
  output logic              buf_last,
  output logic [5:0]        buf_head_addr,
  output logic [2:0]        buf_mode,
  output logic              busy,
  output logic              done
`ifdef PSUM_SEQ_CTRL_PERF_EN
  ,
  output logic [15:0]       perf_stall_cnt
`endif
);

  localparam logic [2:0]        MAX_ROWS_L = 3'(MAX_ROWS);
  localparam logic [CHAN_W-1:0] ONE_C      = CHAN_W'(1);

  state_t              state, state_nxt;
  cfg_t                cfg_q;
  logic [CHAN_W-1:0]   chans_q;
  logic [CHAN_W-1:0]   pass_q;
  logic [2:0]          k_q;
  logic [DRAIN_W-1:0]  drain_q;
  logic [5:0]          head;
  logic                last_beat, last_pass, accept;

  assign last_beat = (k_q == cfg_q.rows - 3'd1);
  assign last_pass = (pass_q == chans_q - ONE_C);
  assign accept    = (state == ACCUM) && pe_valid;

  psum_addr_gen u_addr (
    .k    (k_q),
    .head (head)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    pe_ready      = 1'b0;
    buf_enable    = 1'b0;
    buf_clear     = 1'b0;
    buf_first     = 1'b0;
    buf_last      = 1'b0;
    buf_head_addr = '0;
    busy          = (state != IDLE);
    done          = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = CLEAR;
      CLEAR: begin
        buf_clear = 1'b1;
        state_nxt = ACCUM;
      end
      ACCUM: begin
        pe_ready   = 1'b1;
        buf_enable = pe_valid;
        // Address and framing only escape while a beat is actually written.
        if (pe_valid) begin
          buf_first     = (k_q == 3'd0);
          buf_last      = (cfg_q.rows > 3'd1) && last_beat;
          buf_head_addr = head;
          if (last_beat && last_pass) state_nxt = DRAIN;
        end
      end
      DRAIN: if (drain_q == DRAIN_W'(DRAIN_CYCLES - 1)) state_nxt = DONE;
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q   <= '0;
      chans_q <= '0;
      pass_q  <= '0;
      k_q     <= '0;
      drain_q <= '0;
    end else begin
      if (state == IDLE && start) begin
        cfg_q.mode <= cfg_mode;
        cfg_q.rows <= clamp_rows(cfg_rows, MAX_ROWS_L);
        chans_q    <= (cfg_chans == '0) ? ONE_C : cfg_chans;
        pass_q     <= '0;
        k_q        <= '0;
        drain_q    <= '0;
      end
      if (accept) begin
        if (last_beat) begin
          k_q    <= '0;
          pass_q <= pass_q + ONE_C;
        end else begin
          k_q <= k_q + 3'd1;
        end
      end
      if (state == DRAIN) drain_q <= drain_q + DRAIN_W'(1);
    end
  end

  assign buf_mode = cfg_q.mode;

`ifdef PSUM_SEQ_CTRL_PERF_EN
  always_ff @(posedge clk) begin
    if (rst)                                                    perf_stall_cnt <= '0;
    else if (state == IDLE && start)                            perf_stall_cnt <= '0;
    else if (state == ACCUM && !pe_valid && perf_stall_cnt != 16'hFFFF)
                                                                perf_stall_cnt <= perf_stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_psum_seq_ctrl.sv
// Randomized bench for psum_seq_ctrl against a cycle-offset reference model.
module tb_psum_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, pe_valid;
  logic [2:0] cfg_mode, cfg_rows;
  logic [7:0] cfg_chans;
  logic       pe_ready, buf_clear, buf_enable, buf_first, buf_last, busy, done;
  logic [5:0] buf_head_addr;
  logic [2:0] buf_mode;
`ifdef PSUM_SEQ_CTRL_PERF_EN
  logic [15:0] perf_stall_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int mode_exp = 0;
  int perf_exp = 0;

  always #5 clk = ~clk;

  psum_seq_ctrl #(.MAX_ROWS(4), .CHAN_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_rows(cfg_rows),
    .cfg_chans(cfg_chans), .pe_valid(pe_valid), .pe_ready(pe_ready), .buf_clear(buf_clear),
    .buf_enable(buf_enable), .buf_first(buf_first), .buf_last(buf_last),
    .buf_head_addr(buf_head_addr), .buf_mode(buf_mode), .busy(busy), .done(done)
`ifdef PSUM_SEQ_CTRL_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] obs();
    return {pe_ready, buf_enable, buf_clear, buf_first, buf_last, buf_head_addr, busy, done, buf_mode};
  endfunction

  function automatic logic [15:0] pack(input bit rdy, en, clr, fst, lst, input int head,
                                       input bit bsy, dn, input int mode);
    return {rdy, en, clr, fst, lst, 6'(head), bsy, dn, 3'(mode)};
  endfunction

  task automatic chk_perf(input string tag);
`ifdef PSUM_SEQ_CTRL_PERF_EN
    chk(tag, 32'(perf_stall_cnt), 32'(perf_exp));
`endif
  endtask

  // vmode: 0 = valid always high, 1 = random valid, 2 = valid low for 5 cycles after first beat
  task automatic run_layer(input string name, input int mode, input int rows_cfg, input int chans_cfg,
                           input int vmode, input bit inj, input int rst_beat);
    int rows, chans, total, b, s, c, ndone, stall_run, k, done_at, dn_cyc;
    bit acc, dr, dn, do_rst;
    rows  = (rows_cfg == 0) ? 1 : (rows_cfg > 4) ? 4 : rows_cfg;
    chans = (chans_cfg == 0) ? 1 : chans_cfg;
    total = rows * chans;
    b = 0; s = 0; ndone = 0; stall_run = 0; done_at = -1;

    @(negedge clk);
    start = 1'b1; cfg_mode = 3'(mode); cfg_rows = 3'(rows_cfg); cfg_chans = 8'(chans_cfg);
    pe_valid = 1'($urandom);
    #1 chk({name, ":start_cyc"}, 32'(obs()), 32'(pack(0,0,0,0,0,0,0,0,mode_exp)));
    @(posedge clk);
    mode_exp = mode; perf_exp = 0;

    for (c = 1; c < 600; c++) begin
      @(negedge clk);
      dn_cyc = 2 + total + s + 4;
      acc = (c >= 2) && (b < total);
      dr  = (b == total) && (c >= 2 + total + s) && (c < dn_cyc);
      dn  = (b == total) && (c == dn_cyc);
      case (vmode)
        0: pe_valid = 1'b1;
        1: pe_valid = ($urandom_range(0, 3) != 0);
        default: begin
          if (b == 1 && stall_run < 5) begin pe_valid = 1'b0; stall_run++; end
          else pe_valid = 1'b1;
        end
      endcase
      start = inj ? ($urandom_range(0, 2) == 0) : 1'b0;
      if (inj && dn) start = 1'b1;
      cfg_mode = 3'($urandom); cfg_rows = 3'($urandom); cfg_chans = 8'($urandom);
      do_rst = (rst_beat >= 0) && acc && (b == rst_beat);
      rst = do_rst;
      k = b % rows;
      #1;
      if (acc)
        chk({name, ":accum"}, 32'(obs()),
            32'(pack(1, pe_valid, 0, pe_valid && k == 0, pe_valid && rows > 1 && k == rows-1,
                     (pe_valid && k > 0) ? 8*k - 2 : 0, 1, 0, mode_exp)));
      else if (c == 1)
        chk({name, ":clear"}, 32'(obs()), 32'(pack(0,0,1,0,0,0,1,0,mode_exp)));
      else if (dr)
        chk({name, ":drain"}, 32'(obs()), 32'(pack(0,0,0,0,0,0,1,0,mode_exp)));
      else if (dn)
        chk({name, ":done"}, 32'(obs()), 32'(pack(0,0,0,0,0,0,1,1,mode_exp)));
      chk_perf({name, ":perf"});
      if (done) begin ndone++; if (done_at < 0) done_at = c; end
      if (do_rst) begin
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        mode_exp = 0; perf_exp = 0;
        #1 chk({name, ":post_rst"}, 32'(obs()), 32'(pack(0,0,0,0,0,0,0,0,0)));
        chk_perf({name, ":post_rst_perf"});
        break;
      end
      if (acc && pe_valid) b++;
      if (acc && !pe_valid && perf_exp < 16'hFFFF) begin s++; perf_exp++; end
      if (dn) break;
      @(posedge clk);
    end
    if (c >= 600) chk({name, ":timeout"}, 32'(c), 32'(0));

    start = 1'b0; rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 0) begin @(negedge clk); end
      #1 chk({name, ":idle"}, 32'(obs()), 32'(pack(0,0,0,0,0,0,0,0,mode_exp)));
      chk_perf({name, ":idle_perf"});
      if (done) ndone++;
    end
    if (rst_beat >= 0) begin
      chk({name, ":ndone"}, 32'(ndone), 32'(0));
    end else begin
      chk({name, ":ndone"}, 32'(ndone), 32'(1));
      chk({name, ":done_latency"}, 32'(done_at), 32'(2 + rows*chans + 4 + s));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pe_valid = 1'b0;
    cfg_mode = '0; cfg_rows = '0; cfg_chans = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1 chk("reset", 32'(obs()), 32'(pack(0,0,0,0,0,0,0,0,0)));
    chk_perf("reset_perf");
    rst = 1'b0;

    run_layer("r4c2",      5, 4, 2, 0, 0, -1);
    run_layer("r1c3",      2, 1, 3, 0, 0, -1);
    run_layer("r3c1_stall",3, 3, 1, 2, 0, -1);
    run_layer("inj_start", 6, 2, 3, 0, 1, -1);
    run_layer("rst_mid",   7, 4, 2, 0, 0, 6);
    run_layer("after_rst", 1, 4, 2, 1, 0, -1);
    run_layer("clamp",     4, 7, 0, 0, 0, -1);
    run_layer("rst_drain", 3, 2, 1, 1, 0, 1);
    for (int n = 0; n < 10; n++)
      run_layer("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                int'($urandom_range(0, 4)), 1, 1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
